fetch_pc: RTL and testbench
===========================

FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter WIDTH, default 16: program counter width in bits.
REQ-002 Parameter RESET_PC, default 0: PC value loaded at reset; bit 0 SHALL be 0.
REQ-003 Parameter INC, default 2: sequential PC increment in bytes.
REQ-004 Parameter TIMEOUT, default 15: maximum consecutive unanswered request cycles.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 stall  input  1  downstream hold; suppresses fetch this cycle.
REQ-008 branch_taken  input  1  redirect request from execute.
REQ-009 branch_target  input  WIDTH  redirect address; bit 0 ignored (treated as 0).
REQ-010 halt  input  1  decoded halt; qualified by fetch_valid.
REQ-011 imem_ready  input  1  instruction memory accepts/returns this cycle.
REQ-012 imem_req  output  1  fetch request; address is pc.
REQ-013 pc  output  WIDTH  current fetch address, registered.
REQ-014 pc_next_seq  output  WIDTH  pc + INC, modulo 2^WIDTH, combinational.
REQ-015 fetch_valid  output  1  imem_req AND imem_ready, combinational.
REQ-016 halted  output  1  high in HALTED state.
REQ-017 fetch_err  output  1  sticky memory timeout flag.

Function
REQ-018 States: FETCH, WAIT, HALTED; encoding free.
REQ-019 imem_req = NOT stall AND state != HALTED.
REQ-020 FETCH: imem_req AND NOT imem_ready -> WAIT; otherwise stay in FETCH.
REQ-021 WAIT: fetch_valid -> FETCH; stall drops imem_req but SHALL NOT leave WAIT.
REQ-022 On fetch_valid, pc SHALL update to: branch_target (branch_taken this cycle), else pending target (pending set), else pc + INC.
REQ-023 On fetch_valid, the pending redirect SHALL clear.
REQ-024 When fetch_valid is 0, pc SHALL hold.
REQ-025 branch_taken without fetch_valid SHALL load pending target and set pending; a newer branch overwrites an older pending one.
REQ-026 Address arithmetic wraps: pc = 2^WIDTH-INC with sequential advance -> pc = 0.
REQ-027 halt AND fetch_valid -> HALTED; pc holds the halting instruction address; halt priority exceeds branch_taken in the same cycle.
REQ-028 halt without fetch_valid SHALL be ignored.
REQ-029 HALTED: imem_req = 0, pc frozen, branch_taken ignored, pending unchanged; exit only by reset.
REQ-030 Wait counter: increments each cycle with imem_req = 1 AND imem_ready = 0; clears on fetch_valid or when imem_req = 0.
REQ-031 Counter reaching TIMEOUT SHALL set fetch_err and force HALTED on the next edge.
REQ-032 fetch_err stays set until reset.
REQ-033 Counter width SHALL hold TIMEOUT without overflow.

Reset
REQ-034 rst = 0 at a rising edge SHALL set pc = RESET_PC, state = FETCH, pending = 0, counter = 0, fetch_err = 0, regardless of state, including WAIT and HALTED.
REQ-035 Outputs during/after reset: imem_req = NOT stall, halted = 0, fetch_err = 0, fetch_valid = imem_ready AND NOT stall.
REQ-036 Reset takes priority over every other input in the same cycle.

Verification
REQ-037 Reset, imem_ready = 1, no stall, 4 cycles -> pc 0, 2, 4, 6, 8.
REQ-038 At pc = 4, branch_taken = 1, target 0x0041, ready = 1 -> next pc = 0x0040.
REQ-039 At pc = 8, ready = 0 for 3 cycles with branch to 0x0100 in cycle 2, then ready = 1 -> pc holds 8, then becomes 0x0100.
REQ-040 WIDTH = 16, pc = 0xFFFE, sequential fetch -> pc = 0x0000; pc_next_seq shows 0x0000 beforehand.
REQ-041 halt with fetch_valid at pc = 0x0010 -> halted = 1, pc stays 0x0010, imem_req = 0; branch_taken ignored; reset -> pc = RESET_PC, halted = 0.
REQ-042 ready held 0 for TIMEOUT cycles -> fetch_err = 1, halted = 1 next cycle; stall = 1 during wait pauses and clears counter, no error.

Source files
------------

// File: rtl/fetch_pc.sv
// Instruction fetch program counter: sequential advance, branch redirect with a
// pending slot for redirects that arrive while memory is busy, halt and memory timeout.
module fetch_pc #(
    parameter int WIDTH    = 16,
    parameter int RESET_PC = 0,
    parameter int INC      = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             halt,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic             fetch_valid,
    output logic             halted,
    output logic             fetch_err,
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
    localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);
    localparam logic [CW-1:0]    TIMEOUT_W  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state;
    logic             pending;
    logic [WIDTH-1:0] pending_target;
    logic [CW-1:0]    wait_cnt;
    logic [WIDTH-1:0] target_even;

    // Handshake: a fetch completes in any cycle where imem_req and imem_ready are
    // both high; imem_req is never withheld waiting on imem_ready.
    assign imem_req    = !stall && (state != HALTED);
    assign fetch_valid = imem_req && imem_ready;
    assign pc_next_seq = pc + INC_W;
    assign halted      = (state == HALTED);
    assign fsm_state   = state;
    assign target_even = {branch_target[WIDTH-1:1], 1'b0};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= FETCH;
            pc             <= RESET_PC_W;
            pending        <= 1'b0;
            pending_target <= '0;
            wait_cnt       <= '0;
            fetch_err      <= 1'b0;
        end else if (state != HALTED && wait_cnt == TIMEOUT_W) begin
            // Memory never answered: give up and stop fetching for good.
            state     <= HALTED;
            fetch_err <= 1'b1;
            wait_cnt  <= '0;
        end else if (state != HALTED) begin
            if (!imem_req || fetch_valid) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (fetch_valid) begin
                pending <= 1'b0;
                if (halt) begin
                    state <= HALTED;
                end else begin
                    state <= FETCH;
                    if (branch_taken) begin
                        pc <= target_even;
                    end else if (pending) begin
                        pc <= pending_target;
                    end else begin
                        pc <= pc_next_seq;
                    end
                end
            end else begin
                if (branch_taken) begin
                    pending        <= 1'b1;
                    pending_target <= target_even;
                end
                if (state == FETCH && imem_req) begin
                    state <= WAIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc.sv
// Directed testbench for fetch_pc: sequential fetch, redirects, wrap, halt and timeout.
module tb_fetch_pc;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        halt;
    logic        imem_ready;
    logic        imem_req;
    logic [15:0] pc;
    logic [15:0] pc_next_seq;
    logic        fetch_valid;
    logic        halted;
    logic        fetch_err;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pc dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .halt(halt),
        .imem_ready(imem_ready),
        .imem_req(imem_req),
        .pc(pc),
        .pc_next_seq(pc_next_seq),
        .fetch_valid(fetch_valid),
        .halted(halted),
        .fetch_err(fetch_err),
        .fsm_state(fsm_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic branch(input logic [15:0] t);
        branch_taken  = 1'b1;
        branch_target = t;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b1; branch_taken = 1'b0; branch_target = '0;
        halt = 1'b0; imem_ready = 1'b1;
        tick();
        chk("reset_pc", pc, 0);
        chk("reset_halted", halted, 0);
        chk("reset_err", fetch_err, 0);
        chk("reset_req_stalled", imem_req, 0);
        stall = 1'b0;
        #1;
        chk("reset_req", imem_req, 1);
        chk("reset_valid", fetch_valid, 1);

        // Sequential fetch
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_pc", pc, 2 * i);
        end
        chk("seq_next", pc_next_seq, 16'h000A);

        // Redirect arrives while memory is not ready; taken when ready returns
        imem_ready = 1'b0;
        tick();
        chk("wait1_pc", pc, 16'h0008);
        branch(16'h0100);
        tick();
        chk("wait2_pc", pc, 16'h0008);
        branch_taken = 1'b0;
        tick();
        chk("wait3_pc", pc, 16'h0008);
        imem_ready = 1'b1;
        tick();
        chk("pending_pc", pc, 16'h0100);
        tick();
        chk("after_pending_pc", pc, 16'h0102);

        // Branch with odd target on a live fetch at pc = 4
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("pc4", pc, 16'h0004);
        branch(16'h0041);
        tick();
        branch_taken = 1'b0;
        chk("branch_pc", pc, 16'h0040);

        // Stall holds pc
        stall = 1'b1;
        #1;
        chk("stall_req", imem_req, 0);
        tick();
        chk("stall_pc", pc, 16'h0040);
        stall = 1'b0;

        // Newer pending redirect overwrites older
        imem_ready = 1'b0;
        branch(16'h0200);
        tick();
        branch(16'h0301);
        tick();
        branch_taken = 1'b0;
        imem_ready = 1'b1;
        tick();
        chk("overwrite_pc", pc, 16'h0300);

        // Live branch beats pending target; pending then cleared
        imem_ready = 1'b0;
        branch(16'h0500);
        tick();
        imem_ready = 1'b1;
        branch(16'h0600);
        tick();
        branch_taken = 1'b0;
        chk("live_over_pending", pc, 16'h0600);
        tick();
        chk("pending_cleared", pc, 16'h0602);

        // Address wrap
        branch(16'hFFFE);
        tick();
        branch_taken = 1'b0;
        chk("pc_fffe", pc, 16'hFFFE);
        chk("wrap_next", pc_next_seq, 16'h0000);
        tick();
        chk("wrap_pc", pc, 16'h0000);

        // Halt beats a same-cycle branch; HALTED ignores redirects
        branch(16'h0010);
        tick();
        chk("pc10", pc, 16'h0010);
        halt = 1'b1;
        branch(16'h0080);
        tick();
        halt = 1'b0;
        chk("halt_halted", halted, 1);
        chk("halt_pc", pc, 16'h0010);
        chk("halt_req", imem_req, 0);
        chk("halt_valid", fetch_valid, 0);
        branch(16'h0090);
        tick();
        tick();
        chk("halted_pc_frozen", pc, 16'h0010);
        chk("halted_stays", halted, 1);

        // Reset wins over branch and leaves HALTED
        rst = 1'b0;
        tick();
        rst = 1'b1;
        branch_taken = 1'b0;
        chk("halt_reset_pc", pc, 0);
        chk("halt_reset_halted", halted, 0);

        // Halt without fetch_valid is ignored
        imem_ready = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_ignored", halted, 0);
        imem_ready = 1'b1;
        tick();
        chk("after_ignored_pc", pc, 16'h0002);

        // Stall during a long wait clears the counter
        imem_ready = 1'b0;
        repeat (10) tick();
        stall = 1'b1;
        tick();
        stall = 1'b0;
        repeat (10) tick();
        chk("stall_wait_err", fetch_err, 0);
        chk("stall_wait_halted", halted, 0);

        // Timeout
        stall = 1'b1;
        tick();
        stall = 1'b0;
        repeat (15) tick();
        chk("pre_timeout_err", fetch_err, 0);
        chk("pre_timeout_halted", halted, 0);
        chk("pre_timeout_pc", pc, 16'h0002);
        tick();
        chk("timeout_err", fetch_err, 1);
        chk("timeout_halted", halted, 1);
        imem_ready = 1'b1;
        tick();
        chk("err_sticky", fetch_err, 1);
        chk("timeout_pc", pc, 16'h0002);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("err_reset", fetch_err, 0);
        chk("err_reset_halted", halted, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
